// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared sizes, types and mux helper for the register file
package reg_file_pkg;

    localparam int WIDTH    = 64;
    localparam int NREGS    = 32;
    localparam int ADDR_W   = $clog2(NREGS);
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef logic [WIDTH-1:0]  word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;

    function automatic word_t mux4(input word_t a, input word_t b,
                                   input word_t c, input word_t d,
                                   input logic [1:0] sel);
        case (sel)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - write port and two read ports of the register file
interface reg_file_if;
    import reg_file_pkg::*;

    logic     RegWrite;
    reg_idx_t WriteRegister;
    word_t    WriteData;
    reg_idx_t ReadRegister1;
    reg_idx_t ReadRegister2;
    word_t    ReadData1;
    word_t    ReadData2;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2
    );

endinterface

// File: rtl/reg_row.sv
// rtl/reg_row.sv - one register row: BITS storage bits sharing one enable
module reg_row
    import reg_file_pkg::*;
#(
    parameter int BITS = WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [BITS-1:0] d,
    output logic [BITS-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 31 writable 64-bit registers plus hardwired zero X31, two combinational read ports
module reg_file
    import reg_file_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    reg_file_if.slave bus
);

    localparam int NROWS = NREGS - 1;

    logic [3:0]       dec_hi;
    logic [7:0]       dec_lo;
    logic [NROWS-1:0] row_en;
    word_t            rows [NREGS];
    word_t            rd   [2];

    // 2:4 on the upper index bits selects which 3:8 group may fire
    always_comb begin
        dec_hi = '0;
        dec_hi[bus.WriteRegister[4:3]] = bus.RegWrite;
        dec_lo = '0;
        dec_lo[bus.WriteRegister[2:0]] = 1'b1;
    end

    for (genvar i = 0; i < NROWS; i++) begin : g_row
        assign row_en[i] = dec_hi[i / 8] & dec_lo[i % 8];

        reg_row #(.BITS(WIDTH)) u_row (
            .clk   (clk),
            .reset (reset),
            .en    (row_en[i]),
            .d     (bus.WriteData),
            .q     (rows[i])
        );
    end

    // No storage behind X31; writes to it decode to no row
    assign rows[ZERO_REG] = '0;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        reg_idx_t idx;
        word_t    l1 [8];
        word_t    l2 [2];

        assign idx = (p == 0) ? bus.ReadRegister1 : bus.ReadRegister2;

        always_comb begin
            for (int g = 0; g < 8; g++) begin
                l1[g] = mux4(rows[4*g], rows[4*g+1], rows[4*g+2], rows[4*g+3], idx[1:0]);
            end
            for (int g = 0; g < 2; g++) begin
                l2[g] = mux4(l1[4*g], l1[4*g+1], l1[4*g+2], l1[4*g+3], idx[3:2]);
            end
        end

        // Final level only has two live inputs
        assign rd[p] = idx[4] ? l2[1] : l2[0];
    end

    assign bus.ReadData1 = rd[0];
    assign bus.ReadData2 = rd[1];

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file
module tb_reg_file;
    import reg_file_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    reg_file_if bus ();

    reg_file dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int r1, input int r2);
        bus.ReadRegister1 = reg_idx_t'(r1);
        bus.ReadRegister2 = reg_idx_t'(r2);
        #1;
    endtask

    task automatic wr(input int idx, input word_t data);
        @(negedge clk);
        bus.WriteRegister = reg_idx_t'(idx);
        bus.WriteData     = data;
        bus.RegWrite      = 1'b1;
        @(posedge clk);
        #1;
        bus.RegWrite      = 1'b0;
    endtask

    function automatic word_t pat(input int i);
        return 64'h0123_4567_89AB_0000 | word_t'(i);
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.RegWrite      = 1'b0;
        bus.WriteRegister = '0;
        bus.WriteData     = '0;
        bus.ReadRegister1 = '0;
        bus.ReadRegister2 = '0;

        #2;
        rd(0, 31);
        check("reset_rd1_x0", bus.ReadData1, 64'h0);
        check("reset_rd2_x31", bus.ReadData2, 64'h0);
        rd(30, 15);
        check("reset_rd1_x30", bus.ReadData1, 64'h0);
        check("reset_rd2_x15", bus.ReadData2, 64'h0);

        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 31; i++) wr(i, pat(i));
        for (int i = 0; i < 31; i++) begin
            rd(i, i);
            check($sformatf("fill_rd1_x%0d", i), bus.ReadData1, pat(i));
            check($sformatf("fill_rd2_x%0d", i), bus.ReadData2, pat(i));
        end
        rd(31, 31);
        check("x31_rd1_zero", bus.ReadData1, 64'h0);
        check("x31_rd2_zero", bus.ReadData2, 64'h0);
        rd(4, 27);
        check("indep_rd1_x4", bus.ReadData1, pat(4));
        check("indep_rd2_x27", bus.ReadData2, pat(27));

        wr(31, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(31, 31);
        check("xzr_write_rd1", bus.ReadData1, 64'h0);
        for (int i = 0; i < 31; i++) begin
            rd(31, i);
            check($sformatf("xzr_keep_x%0d", i), bus.ReadData2, pat(i));
        end

        wr(5, 64'hA5A5);
        @(negedge clk);
        bus.WriteRegister = 5'd5;
        bus.WriteData     = 64'h5A5A;
        bus.RegWrite      = 1'b0;
        rd(0, 5);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("gate_x5_cyc%0d", c), bus.ReadData2, 64'hA5A5);
        end

        wr(7, 64'h1111);
        @(negedge clk);
        bus.WriteRegister = 5'd7;
        bus.WriteData     = 64'h2222;
        bus.RegWrite      = 1'b1;
        rd(7, 6);
        check("rdw_before_edge", bus.ReadData1, 64'h1111);
        @(posedge clk);
        #1;
        bus.RegWrite = 1'b0;
        check("rdw_after_edge", bus.ReadData1, 64'h2222);

        @(negedge clk);
        #1;
        reset = 1'b1;
        rd(0, 0);
        check("async_rst_rd1_x0", bus.ReadData1, 64'h0);
        check("async_rst_rd2_x0", bus.ReadData2, 64'h0);
        rd(15, 15);
        check("async_rst_rd1_x15", bus.ReadData1, 64'h0);
        check("async_rst_rd2_x15", bus.ReadData2, 64'h0);
        rd(30, 30);
        check("async_rst_rd1_x30", bus.ReadData1, 64'h0);
        check("async_rst_rd2_x30", bus.ReadData2, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        wr(3, 64'h0BAD);
        @(negedge clk);
        bus.WriteRegister = 5'd3;
        bus.WriteData     = 64'hDEAD;
        bus.RegWrite      = 1'b1;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        rd(3, 3);
        check("rst_prio_x3_rd1", bus.ReadData1, 64'h0);
        check("rst_prio_x3_rd2", bus.ReadData2, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_release_pre_edge", bus.ReadData1, 64'h0);
        @(posedge clk);
        #1;
        bus.RegWrite = 1'b0;
        check("rst_release_write_x3", bus.ReadData1, 64'hDEAD);
        rd(7, 5);
        check("rst_release_x7_clear", bus.ReadData1, 64'h0);
        check("rst_release_x5_clear", bus.ReadData2, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
